// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU for the execute stage.
//
// Accepts one operation per in_valid/in_ready transfer and presents a
// registered result with negative/zero/overflow/carry_out/illegal flags
// that are held until consumed through out_valid/out_ready.
//
// Optional multiply: define SEQ_ALU_MUL_EN to build the iterative
// shift-add multiplier for opcode 001 (WIDTH cycles, busy while running).
// Without it, opcode 001 is reported as illegal and busy is tied low.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid, in_ready    request handshake
//   cntrl, A, B           opcode and operands, captured on accept
//   out_valid, out_ready  result handshake
//   result                registered result
//   negative, zero        derived from the value loaded into result
//   overflow, carry_out   signed / unsigned overflow
//   illegal               accepted opcode was illegal
//   busy                  multiply in progress
module seq_alu #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cntrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal,
  output logic             busy
);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0 || (1 << CNT_W) <= WIDTH) begin : g_bad_param
    $error("seq_alu: illegal WIDTH/CNT_W combination");
  end

  // Returns {overflow, carry_out, sum}. Subtraction is A + ~B + 1, so
  // carry_out=1 means no borrow. Carry into the MSB is recovered from the
  // MSB sum bit and the two MSB operand bits.
  function automatic logic [WIDTH+1:0] add_flags(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b,
                                                 input logic                    sub);
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   full;
    logic             cin_msb;
    bop     = sub ? ~b : b;
    full    = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, sub};
    cin_msb = full[WIDTH-1] ^ a[WIDTH-1] ^ bop[WIDTH-1];
    return {cin_msb ^ full[WIDTH], full};
  endfunction

  logic                   accept;
  logic [WIDTH+1:0]       as_res;
  logic signed [WIDTH-1:0] nxt_res;
  logic                   nxt_v;
  logic                   nxt_c;
  logic                   nxt_il;

  assign accept = in_valid && in_ready;
  assign as_res = add_flags(A, B, cntrl[0]);

  // Single-cycle opcodes; 001 falls to default and is illegal unless the
  // multiplier path claims it before this value is used.
  always_comb begin
    nxt_res = '0;
    nxt_v   = 1'b0;
    nxt_c   = 1'b0;
    nxt_il  = 1'b0;
    case (cntrl)
      3'b000: nxt_res = B;
      3'b010, 3'b011: begin
        nxt_res = as_res[WIDTH-1:0];
        nxt_c   = as_res[WIDTH];
        nxt_v   = as_res[WIDTH+1];
      end
      3'b100: nxt_res = A & B;
      3'b101: nxt_res = A | B;
      3'b110: nxt_res = A ^ B;
      default: nxt_il = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               mul_last;

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CNT_W'(WIDTH - 1));
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);

  // Multiply datapath: operands captured on accept, one bit per cycle.
  always_ff @(posedge clk) begin
    if (accept && cntrl == 3'b001) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      illegal   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      if (state == S_MUL) begin
        cnt <= cnt + 1'b1;
        if (mul_last) begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
          result    <= acc_nxt[WIDTH-1:0];
          negative  <= acc_nxt[WIDTH-1];
          zero      <= (acc_nxt[WIDTH-1:0] == '0);
          carry_out <= |acc_nxt[2*WIDTH-1:WIDTH];
          overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
          illegal   <= 1'b0;
        end
      end else if (accept && cntrl == 3'b001) begin
        state <= S_MUL;
        busy  <= 1'b1;
        cnt   <= '0;
      end else
`endif
      if (accept) begin
        out_valid <= 1'b1;
        result    <= nxt_res;
        negative  <= nxt_res[WIDTH-1];
        zero      <= (nxt_res == '0);
        overflow  <= nxt_v;
        carry_out <= nxt_c;
        illegal   <= nxt_il;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] r;
    logic n, z, v, c, il;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   cntrl = 3'b000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         negative, zero, overflow, carry_out, illegal, busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  seq_alu #(.WIDTH(W), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .cntrl(cntrl), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .negative(negative), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    e = '0;
    case (op)
      3'b000: e.r = b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0]; e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        e.r = s[W-1:0]; e.c = s[W];
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'b100: e.r = a & b;
      3'b101: e.r = a | b;
      3'b110: e.r = a ^ b;
`ifdef SEQ_ALU_MUL_EN
      3'b001: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.r = p[W-1:0]; e.c = |p[2*W-1:W]; e.v = e.c;
      end
`endif
      default: e.il = 1'b1;
    endcase
    e.n = e.r[W-1];
    e.z = (e.r == '0);
    return e;
  endfunction

  // Scoreboard: compare each output transfer against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      exp_t e;
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected result %h with empty queue", result);
      end else begin
        e = q.pop_front();
        n_checks++;
        if (result !== e.r) begin
          n_fail++; $display("FAIL sb_result got %h want %h", result, e.r);
        end
        n_checks++;
        if ({negative, zero, overflow, carry_out, illegal} !== {e.n, e.z, e.v, e.c, e.il}) begin
          n_fail++;
          $display("FAIL sb_flags nzvci got %b want %b",
                   {negative, zero, overflow, carry_out, illegal}, {e.n, e.z, e.v, e.c, e.il});
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waited);
    waited = 0;
    in_valid = 1'b1; cntrl = op; A = a; B = b;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout in_ready got 0 want 1");
    end else begin
      q.push_back(model(op, a, b));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, negative, zero, overflow, carry_out, illegal, busy} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0000000",
                         {out_valid, negative, zero, overflow, carry_out, illegal, busy});
    end
    n_checks++;
    if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    int w;
    out_ready = 1'b1;
    issue(3'b010, 64'd1, 64'd1, w);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 64'd2) begin
      n_fail++; $display("FAIL add_latency got v=%b r=%h want v=1 r=2", out_valid, result);
    end
    @(posedge clk); #1;
    issue(3'b010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, w);
    issue(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, w);
    issue(3'b011, 64'd5, 64'd7, w);
    issue(3'b000, 64'h1234, 64'hFFFF_0000_0000_0001, w);
    @(posedge clk); #1;
  endtask

  task automatic test_sub_hold;
    int w;
    logic [W-1:0] want;
    want = 64'h7000_0000_0000_0001;
    out_ready = 1'b0;
    issue(3'b011, 64'h8000_0000_0000_0000, 64'h0FFF_FFFF_FFFF_FFFF, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || result !== want || carry_out !== 1'b1 || overflow !== 1'b1) begin
        n_fail++; $display("FAIL hold_stable cyc %0d got v=%b r=%h c=%b o=%b want v=1 r=%h c=1 o=1",
                           i, out_valid, result, carry_out, overflow, want);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc %0d got %b want 0", i, in_ready); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int w0, w1, w2;
    out_ready = 1'b1;
    issue(3'b110, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_FFFF, w0);
    issue(3'b100, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FFFF_0000, w1);
    issue(3'b101, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, w2);
    n_checks++;
    if (w0 + w1 + w2 != 0) begin
      n_fail++; $display("FAIL b2b_in_ready stall cycles got %0d want 0", w0 + w1 + w2);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    int w;
    out_ready = 1'b1;
    issue(3'b111, 64'd5, 64'd7, w);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || zero !== 1'b1 || result !== '0) begin
      n_fail++; $display("FAIL illegal_111 got v=%b il=%b z=%b r=%h want 1 1 1 0",
                         out_valid, illegal, zero, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int w, cyc;
    out_ready = 1'b1;
    issue(3'b001, 64'hFFFF_FFFF, 64'h1_0000_0001, w);
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
`ifdef SEQ_ALU_MUL_EN
    if (cyc != W) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want %0d", cyc, W); end
`else
    if (cyc != 0) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want 0", cyc); end
`endif
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_done out_valid got %b want 1", out_valid); end
    @(posedge clk); #1;
    issue(3'b001, 64'h8000_0000_0000_0000, 64'd2, w);
    for (int i = 0; i < W + 4; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int w, seen;
    logic [2:0] op;
`ifdef SEQ_ALU_MUL_EN
    op = 3'b001; out_ready = 1'b1;
`else
    op = 3'b010; out_ready = 1'b0;
`endif
    issue(op, 64'h1234_5678, 64'h9ABC_DEF0, w);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    void'(q.pop_back());
    n_checks++;
    if ({out_valid, negative, zero, overflow, carry_out, illegal, busy} !== 7'b0 || result !== '0) begin
      n_fail++; $display("FAIL reset_mid got ctrl=%b r=%h want 0",
                         {out_valid, negative, zero, overflow, carry_out, illegal, busy}, result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 16; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_mid_no_valid got %0d valid cycles want 0", seen); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_hold();
    test_back_to_back();
    test_illegal();
    test_mul();
    test_reset_mid();
    repeat (3) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL sb_drain pending got %0d want 0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
